// File: rtl/calibration_list_loader.sv
// rtl/calibration_list_loader.sv - streaming ASCII "+N\n-M\n" parser into a signed calibration list
// Each accepted byte updates the per-line parse context; a line commits on LF or on in_last.
module calibration_list_loader #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 1024,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] calibration_list [DEPTH],
  output logic [LEN_W-1:0] calibration_list_length,
  output logic             done,
  output logic             error,
  output logic [2:0]       error_code
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH+3:0] MAG_MAX = {5'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state_q, state_d;
  logic             neg_q, neg_d, have_digit_q, have_digit_d;
  logic             have_sign_q, have_sign_d, skip_q, skip_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       err_q, err_d;
  logic             error_q, error_d, done_q, done_d, in_ready_q, in_ready_d;

  logic [WIDTH-1:0] list_q [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic             commit, cmt_neg;
  logic [WIDTH-1:0] cmt_mag;
  logic [WIDTH+3:0] prod;

  always_comb begin
    state_d      = state_q;
    neg_d        = neg_q;
    mag_d        = mag_q;
    have_digit_d = have_digit_q;
    have_sign_d  = have_sign_q;
    skip_d       = skip_q;
    len_d        = len_q;
    err_d        = err_q;
    done_d       = done_q;
    in_ready_d   = in_ready_q;
    commit       = 1'b0;
    cmt_neg      = neg_q;
    cmt_mag      = mag_q;
    wr_en        = 1'b0;
    wr_addr      = len_q[AW-1:0];
    prod         = {4'b0, mag_q} * (WIDTH+4)'(10) + (WIDTH+4)'(in_data[3:0]);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD;
          neg_d        = 1'b0;
          mag_d        = '0;
          have_digit_d = 1'b0;
          have_sign_d  = 1'b0;
          skip_d       = 1'b0;
          len_d        = '0;
          err_d        = '0;
          done_d       = 1'b0;
          in_ready_d   = 1'b1;
        end
      end
      default: begin
        if (in_valid) begin
          if (in_data == 8'h0D) begin
            // carriage returns are transparent everywhere
          end else if (in_data == 8'h0A) begin
            if (!skip_q && have_digit_q) commit = 1'b1;
            else if (!skip_q && have_sign_q) err_d[0] = 1'b1;
            neg_d        = 1'b0;
            mag_d        = '0;
            have_digit_d = 1'b0;
            have_sign_d  = 1'b0;
            skip_d       = 1'b0;
          end else if (skip_q) begin
          end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
            if (prod > MAG_MAX) begin
              err_d[1] = 1'b1;
              skip_d   = 1'b1;
            end else begin
              mag_d        = prod[WIDTH-1:0];
              have_digit_d = 1'b1;
            end
          end else if ((in_data == 8'h2B || in_data == 8'h2D) && !have_sign_q && !have_digit_q) begin
            have_sign_d = 1'b1;
            neg_d       = (in_data == 8'h2D);
          end else begin
            err_d[0] = 1'b1;
            skip_d   = 1'b1;
          end

          // in_last acts as an implicit line end for an unterminated final line
          if (in_last) begin
            if (in_data != 8'h0A) begin
              cmt_neg = neg_d;
              cmt_mag = mag_d;
              if (!skip_d && have_digit_d) commit = 1'b1;
              else if (!skip_d && have_sign_d) err_d[0] = 1'b1;
            end
            state_d    = DONE;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
          end

          if (commit) begin
            if (len_q == LEN_W'(DEPTH)) begin
              err_d[2] = 1'b1;
            end else begin
              wr_en = 1'b1;
              len_d = len_q + LEN_W'(1);
            end
          end
        end
      end
    endcase

    wr_data = cmt_neg ? (~cmt_mag + WIDTH'(1)) : cmt_mag;
    error_d = |err_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      neg_q        <= 1'b0;
      mag_q        <= '0;
      have_digit_q <= 1'b0;
      have_sign_q  <= 1'b0;
      skip_q       <= 1'b0;
      len_q        <= '0;
      err_q        <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      neg_q        <= neg_d;
      mag_q        <= mag_d;
      have_digit_q <= have_digit_d;
      have_sign_q  <= have_sign_d;
      skip_q       <= skip_d;
      len_q        <= len_d;
      err_q        <= err_d;
      error_q      <= error_d;
      done_q       <= done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) list_q[wr_addr] <= wr_data;
  end

  assign calibration_list        = list_q;
  assign calibration_list_length = len_q;
  assign done                    = done_q;
  assign error                   = error_q;
  assign error_code              = err_q;
  assign in_ready                = in_ready_q;

endmodule

// File: tb/tb_calibration_list_loader.sv
// tb/tb_calibration_list_loader.sv - scoreboard bench for calibration_list_loader
module tb_calibration_list_loader;

  localparam int WIDTH = 20;
  localparam int DEPTH = 1024;
  localparam int LEN_W = 11;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             in_last = 1'b0;
  logic [WIDTH-1:0] calibration_list [DEPTH];
  logic [LEN_W-1:0] calibration_list_length;
  logic             done;
  logic             error;
  logic [2:0]       error_code;

  int checks = 0;
  int errors = 0;
  int sb[$];

  calibration_list_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .calibration_list(calibration_list),
    .calibration_list_length(calibration_list_length),
    .done(done),
    .error(error),
    .error_code(error_code)
  );

  always #5 CLK = ~CLK;

  task automatic do_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge CLK);
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge CLK);
    if (last) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_str(input string s, input bit last_at_end, input bit toggle);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_at_end && (i == s.len() - 1), toggle && (i % 2 == 1));
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({in_ready, done, error, error_code} !== 6'b0 || calibration_list_length !== '0) begin
      errors++;
      $display("FAIL reset rdy=%0b done=%0b err=%0b code=%b len=%0d required all zero",
               in_ready, done, error, error_code, calibration_list_length);
    end
  endtask

  task automatic test_basic();
    int e;
    do_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t1_ready in_ready=%0b required=1", in_ready);
    end
    sb.push_back(1); sb.push_back(-2); sb.push_back(3); sb.push_back(1);
    send_str("+1\n-2\n+3\n+1", 1'b1, 1'b0);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL t1_done done=%0b rdy=%0b err=%0b required 1,0,0", done, in_ready, error);
    end
    checks++;
    if (calibration_list_length !== LEN_W'(sb.size())) begin
      errors++;
      $display("FAIL t1_length got=%0d required=%0d", calibration_list_length, sb.size());
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      checks++;
      if (calibration_list[i] !== WIDTH'(e)) begin
        errors++;
        $display("FAIL t1_entry%0d got=%0d required=%0d", i, $signed(calibration_list[i]), e);
      end
    end
  endtask

  task automatic test_cr_blank_gaps();
    int e;
    do_start();
    sb.push_back(7); sb.push_back(-13);
    send_str("+7\r\n\n-13\n", 1'b1, 1'b1);
    checks++;
    if (done !== 1'b1 || error_code !== 3'b000) begin
      errors++;
      $display("FAIL t2_status done=%0b code=%b required 1,000", done, error_code);
    end
    checks++;
    if (calibration_list_length !== LEN_W'(sb.size())) begin
      errors++;
      $display("FAIL t2_length got=%0d required=%0d", calibration_list_length, sb.size());
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      checks++;
      if (calibration_list[i] !== WIDTH'(e)) begin
        errors++;
        $display("FAIL t2_entry%0d got=%0d required=%0d", i, $signed(calibration_list[i]), e);
      end
    end
  endtask

  task automatic test_overflow();
    int e;
    do_start();
    sb.push_back(524287); sb.push_back(5);
    send_str("+524287\n-524288\n+5\n", 1'b1, 1'b0);
    checks++;
    if (error_code !== 3'b010 || error !== 1'b1) begin
      errors++;
      $display("FAIL t3_code code=%b err=%0b required 010,1", error_code, error);
    end
    checks++;
    if (calibration_list_length !== LEN_W'(sb.size())) begin
      errors++;
      $display("FAIL t3_length got=%0d required=%0d", calibration_list_length, sb.size());
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      checks++;
      if (calibration_list[i] !== WIDTH'(e)) begin
        errors++;
        $display("FAIL t3_entry%0d got=%0d required=%0d", i, $signed(calibration_list[i]), e);
      end
    end
  endtask

  task automatic test_bad_chars();
    int e;
    do_start();
    sb.push_back(9);
    send_str("+1x2\n-\n4-\n+9\n", 1'b1, 1'b0);
    checks++;
    if (error_code !== 3'b001) begin
      errors++;
      $display("FAIL t4_code code=%b required=001", error_code);
    end
    checks++;
    if (calibration_list_length !== LEN_W'(sb.size())) begin
      errors++;
      $display("FAIL t4_length got=%0d required=%0d", calibration_list_length, sb.size());
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      checks++;
      if (calibration_list[i] !== WIDTH'(e)) begin
        errors++;
        $display("FAIL t4_entry%0d got=%0d required=%0d", i, $signed(calibration_list[i]), e);
      end
    end
  endtask

  task automatic test_list_full();
    int e;
    int bad;
    do_start();
    for (int n = 0; n <= DEPTH; n++) begin
      if (n < DEPTH) sb.push_back(1);
      send_str("+1\n", n == DEPTH, 1'b0);
    end
    checks++;
    if (calibration_list_length !== LEN_W'(DEPTH) || error_code !== 3'b100 || done !== 1'b1) begin
      errors++;
      $display("FAIL t5_full len=%0d code=%b done=%0b required %0d,100,1",
               calibration_list_length, error_code, done, DEPTH);
    end
    bad = 0;
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      if (calibration_list[i] !== WIDTH'(e)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL t5_entries wrong_entries=%0d required=0", bad);
    end
  endtask

  task automatic test_reset_mid_load();
    int e;
    do_start();
    send_str("+1\n+2\n+3\n+4", 1'b0, 1'b0);
    in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || calibration_list_length !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL t6_reset rdy=%0b len=%0d done=%0b required 0,0,0",
               in_ready, calibration_list_length, done);
    end
    sb.delete();
    do_start();
    sb.push_back(-5);
    send_str("-5\n", 1'b1, 1'b0);
    checks++;
    if (calibration_list_length !== LEN_W'(sb.size()) || done !== 1'b1) begin
      errors++;
      $display("FAIL t6_length got=%0d done=%0b required=%0d,1", calibration_list_length, done, sb.size());
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      checks++;
      if (calibration_list[i] !== WIDTH'(e)) begin
        errors++;
        $display("FAIL t6_entry%0d got=%0d required=%0d", i, $signed(calibration_list[i]), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cr_blank_gaps();
    test_overflow();
    test_bad_chars();
    test_list_full();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
